// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: FSM encodings,
// skid buffer depth and default data/length widths.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SKID_DEPTH    = 3;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_LEN_WIDTH = 8;

endpackage

// File: rtl/fifo_burst_reader_skid.sv
// Three-entry in-order skid buffer; dout always shows the head entry,
// so it stays stable while the consumer withholds pop.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem_r [SKID_DEPTH];
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic [1:0]       occ_r;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Storage, circular pointers and occupancy count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            occ_r    <= 2'd0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   occ_r <= occ_r + 2'd1;
                2'b01:   occ_r <= occ_r - 2'd1;
                default: occ_r <= occ_r;
            endcase
        end
    end

    assign dout = mem_r[rd_ptr_r];
    assign occ  = occ_r;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops exactly len_i words from a sync FIFO and
// streams them out through a skid buffer that hides the FIFO read latency.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_rd_error_i,
    output logic [WIDTH-1:0]     m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 m_last_o
);

    localparam logic [LEN_WIDTH-1:0] LEN_ZERO = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_e               state_r;
    state_e               state_nxt_s;
    logic [LEN_WIDTH-1:0] len_r;
    logic [LEN_WIDTH-1:0] issued_cnt_r;
    logic [LEN_WIDTH-1:0] sent_cnt_r;
    logic                 inflight_r;
    logic                 error_r;
    logic [1:0]           occ_s;
    logic                 rd_en_s;
    logic                 push_s;
    logic                 drop_s;
    logic                 pop_s;
    logic                 valid_s;
    logic                 last_s;
    logic                 accept_s;

    assign push_s   = inflight_r & ~fifo_rd_error_i;
    assign drop_s   = inflight_r & fifo_rd_error_i;
    assign valid_s  = (occ_s != 2'd0);
    assign last_s   = valid_s & (sent_cnt_r == (len_r - LEN_ONE));
    assign pop_s    = valid_s & m_ready_i;
    assign accept_s = (state_r == ST_IDLE) & start_i;

    // Issue a read only when the buffer can absorb every word already in flight
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == ST_RUN) && !fifo_empty_i && (issued_cnt_r != len_r) &&
            (({1'b0, occ_s} + {2'b00, inflight_r}) < 3'(SKID_DEPTH))) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = (len_i == LEN_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, burst counters, in-flight flag and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= ST_IDLE;
            len_r        <= LEN_ZERO;
            issued_cnt_r <= LEN_ZERO;
            sent_cnt_r   <= LEN_ZERO;
            inflight_r   <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            inflight_r <= rd_en_s;
            if (accept_s) begin
                len_r        <= len_i;
                issued_cnt_r <= LEN_ZERO;
                sent_cnt_r   <= LEN_ZERO;
            end else begin
                len_r <= len_r;
                // A failed word is un-counted so it is requested again
                case ({rd_en_s, drop_s})
                    2'b10:   issued_cnt_r <= issued_cnt_r + LEN_ONE;
                    2'b01:   issued_cnt_r <= issued_cnt_r - LEN_ONE;
                    default: issued_cnt_r <= issued_cnt_r;
                endcase
                if (pop_s) begin
                    sent_cnt_r <= sent_cnt_r + LEN_ONE;
                end else begin
                    sent_cnt_r <= sent_cnt_r;
                end
            end
            if (drop_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push_s),
        .din    (fifo_rdata_i),
        .pop    (pop_s),
        .dout   (m_data_o),
        .occ    (occ_s)
    );

    assign fifo_rd_en_o = rd_en_s;
    assign m_valid_o    = valid_s;
    assign m_last_o     = last_s;
    assign busy_o       = (state_r != ST_IDLE);
    assign done_o       = (state_r == ST_DONE);
    assign error_o      = error_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural sync FIFO
// (one-cycle read latency, optional injected read error) in front of it.
module tb_fifo_burst_reader;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       start_i = 1'b0;
    logic [7:0] len_i = 8'd0;
    logic       busy_o, done_o, error_o;
    logic       fifo_empty_i;
    logic       fifo_rd_en_o;
    logic [7:0] fifo_rdata_i = 8'h00;
    logic       fifo_rd_error_i = 1'b0;
    logic [7:0] m_data_o;
    logic       m_valid_o;
    logic       m_ready_i = 1'b1;
    logic       m_last_o;

    int checks = 0;
    int errors = 0;

    fifo_burst_reader #(.WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .len_i           (len_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .fifo_empty_i    (fifo_empty_i),
        .fifo_rd_en_o    (fifo_rd_en_o),
        .fifo_rdata_i    (fifo_rdata_i),
        .fifo_rd_error_i (fifo_rd_error_i),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_ready_i       (m_ready_i),
        .m_last_o        (m_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural FIFO: an errored read returns junk and does not consume the word
    logic [7:0] fifo_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int fifo_rd_num = 0;
    int err_at = 0;
    assign fifo_empty_i = (rd_ptr == wr_ptr);

    always @(posedge clk_i) begin
        if (fifo_rd_en_o) begin
            fifo_rd_num <= fifo_rd_num + 1;
            if (fifo_rd_num + 1 == err_at) begin
                fifo_rdata_i    <= 8'hEE;
                fifo_rd_error_i <= 1'b1;
            end else begin
                fifo_rdata_i    <= fifo_mem[rd_ptr];
                rd_ptr          <= rd_ptr + 1;
                fifo_rd_error_i <= 1'b0;
            end
        end else begin
            fifo_rd_error_i <= 1'b0;
        end
    end

    // Monitor: cycle count, beat log, read/done counters, hold-stability
    int cyc = 0;
    logic [7:0] beat_data [$];
    logic       beat_last [$];
    int         beat_cyc  [$];
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int stab_viol = 0;
    logic prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_hold <= 1'b0;
        end else begin
            if (fifo_rd_en_o) rd_cnt <= rd_cnt + 1;
            if (m_valid_o && m_ready_i) begin
                beat_data.push_back(m_data_o);
                beat_last.push_back(m_last_o);
                beat_cyc.push_back(cyc);
            end
            if (done_o) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (prev_hold && (m_data_o != prev_data)) stab_viol <= stab_viol + 1;
            prev_hold <= m_valid_o && !m_ready_i;
            prev_data <= m_data_o;
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    // Cycle c of a burst is the period after edge c-1; edge 0 samples start_i
    task automatic start_burst(input logic [7:0] len, output int t0);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        len_i   = len;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        t0 = cyc - 1;
    endtask

    task automatic wait_cycle(input int t0, input int c);
        while (cyc < t0 + c) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i); #1;
            if (done_cnt > base) break;
        end
        check_eq("done_seen", int'(done_cnt > base), 1);
    endtask

    task automatic check_burst(input string tag, input int base, input int n, input logic [7:0] first);
        check_eq({tag, "_nbeats"}, beat_data.size() - base, n);
        for (int i = 0; (i < n) && (base + i < beat_data.size()); i++) begin
            check_eq({tag, "_data"}, int'(beat_data[base + i]), int'(first) + i);
            check_eq({tag, "_last"}, int'(beat_last[base + i]), int'(i == n - 1));
        end
    endtask

    int t0, bb, rb, db, gap;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        check_eq("rst_error", error_o, 0);
        check_eq("rst_rden", fifo_rd_en_o, 0);
        check_eq("rst_valid", m_valid_o, 0);
        check_eq("rst_data", m_data_o, 0);
        check_eq("rst_last", m_last_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic burst of 4 at full rate
        for (int i = 0; i < 4; i++) push_word(8'hA0 + 8'(i));
        bb = beat_data.size(); rb = rd_cnt; db = done_cnt;
        m_ready_i = 1'b1;
        start_burst(8'd4, t0);
        wait_done(db, 40);
        check_burst("basic", bb, 4, 8'hA0);
        check_eq("basic_rd", rd_cnt - rb, 4);
        check_eq("basic_first_cyc", (beat_data.size() > bb) ? beat_cyc[bb] - t0 : -1, 3);
        check_eq("basic_last_cyc", (beat_data.size() > bb + 3) ? beat_cyc[bb + 3] - t0 : -1, 6);
        check_eq("basic_done_cyc", done_cyc - t0, 7);

        // Backpressure: stream stalled through cycle 10
        for (int i = 0; i < 8; i++) push_word(8'hB0 + 8'(i));
        bb = beat_data.size(); rb = rd_cnt; db = done_cnt;
        m_ready_i = 1'b0;
        start_burst(8'd8, t0);
        wait_cycle(t0, 10);
        check_eq("bp_rd_stalled", rd_cnt - rb, 3);
        check_eq("bp_valid", m_valid_o, 1);
        check_eq("bp_head", m_data_o, 8'hB0);
        wait_cycle(t0, 11);
        m_ready_i = 1'b1;
        wait_done(db, 60);
        check_burst("bp", bb, 8, 8'hB0);
        check_eq("bp_rd", rd_cnt - rb, 8);
        check_eq("bp_stable", stab_viol, 0);

        // Empty stall: three words now, three more at cycle 10
        for (int i = 0; i < 3; i++) push_word(8'hC0 + 8'(i));
        bb = beat_data.size(); rb = rd_cnt; db = done_cnt;
        start_burst(8'd6, t0);
        wait_cycle(t0, 10);
        for (int i = 3; i < 6; i++) push_word(8'hC0 + 8'(i));
        wait_done(db, 60);
        check_burst("empty", bb, 6, 8'hC0);
        gap = (beat_data.size() > bb + 3) ? beat_cyc[bb + 3] - beat_cyc[bb + 2] : -1;
        check_eq("empty_gap", gap, 7);
        check_eq("empty_done_cyc", done_cyc - t0, 15);
        check_eq("empty_rd", rd_cnt - rb, 6);
        check_eq("empty_error", error_o, 0);

        // Zero length
        rb = rd_cnt; db = done_cnt;
        start_burst(8'd0, t0);
        check_eq("zl_busy", busy_o, 1);
        check_eq("zl_done", done_o, 1);
        repeat (3) @(posedge clk_i);
        #1;
        check_eq("zl_done_cnt", done_cnt - db, 1);
        check_eq("zl_done_cyc", done_cyc - t0, 1);
        check_eq("zl_rd", rd_cnt - rb, 0);
        check_eq("zl_idle", busy_o, 0);

        // start_i while busy is ignored
        for (int i = 0; i < 4; i++) push_word(8'hE0 + 8'(i));
        bb = beat_data.size(); rb = rd_cnt; db = done_cnt;
        start_burst(8'd4, t0);
        wait_cycle(t0, 2);
        start_i = 1'b1;
        len_i   = 8'd2;
        wait_cycle(t0, 3);
        start_i = 1'b0;
        wait_done(db, 40);
        repeat (4) @(posedge clk_i);
        #1;
        check_burst("busy_start", bb, 4, 8'hE0);
        check_eq("busy_start_rd", rd_cnt - rb, 4);
        check_eq("busy_start_done", done_cnt - db, 1);

        // Read error on the second read
        for (int i = 0; i < 4; i++) push_word(8'hD0 + 8'(i));
        bb = beat_data.size(); rb = rd_cnt; db = done_cnt;
        check_eq("err_clear", error_o, 0);
        err_at = fifo_rd_num + 2;
        start_burst(8'd4, t0);
        wait_done(db, 40);
        check_eq("err_set", error_o, 1);
        check_burst("err", bb, 4, 8'hD0);
        check_eq("err_rd", rd_cnt - rb, 5);
        repeat (5) @(posedge clk_i);
        #1;
        check_eq("err_sticky", error_o, 1);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) push_word(8'hF0 + 8'(i));
        m_ready_i = 1'b0;
        start_burst(8'd5, t0);
        wait_cycle(t0, 5);
        check_eq("mid_valid", m_valid_o, 1);
        #3;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_busy", busy_o, 0);
        check_eq("mid_done", done_o, 0);
        check_eq("mid_error", error_o, 0);
        check_eq("mid_rden", fifo_rd_en_o, 0);
        check_eq("mid_valid0", m_valid_o, 0);
        check_eq("mid_data", m_data_o, 0);
        check_eq("mid_last", m_last_o, 0);
        #3;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_eq("post_busy", busy_o, 0);
        check_eq("post_valid", m_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
